// File: rtl/round_scoreboard_pkg.sv
// Shared types and helpers for the duck-hunt round/score controller.
// Holds the FSM state enum, score-width derivation and saturating score arithmetic.
package scoreboard_pkg;

  typedef enum logic [1:0] {IDLE, CHECK, CONVERT, OVER} state_t;

  function automatic int score_max_f(input int digits);
    int m;
    m = 1;
    for (int d = 0; d < digits; d++) m = m * 10;
    return m - 1;
  endfunction

  function automatic int score_w_f(input int digits);
    return $clog2(score_max_f(digits) + 1);
  endfunction

  function automatic int sat_add(input int a, input int b, input int max);
    return (a + b > max) ? max : a + b;
  endfunction

  function automatic int sat_sub(input int a, input int b);
    return (a >= b) ? a - b : 0;
  endfunction

endpackage

// File: rtl/round_scoreboard_if.sv
// Event inputs and score/round status of round_scoreboard.
// master = event source and status reader, slave = the scoreboard itself.
interface round_scoreboard_if import scoreboard_pkg::*; #(
  parameter int BIRDS_PER_ROUND = 10,
  parameter int SCORE_DIGITS    = 4,
  parameter int ROUND_W         = 4
);
  localparam int CNT_W   = $clog2(BIRDS_PER_ROUND + 1);
  localparam int SCORE_W = score_w_f(SCORE_DIGITS);

  logic                       hit_evt;
  logic                       escape_evt;
  logic                       busy;
  logic [BIRDS_PER_ROUND-1:0] birds_left;
  logic [BIRDS_PER_ROUND-1:0] hit_mask;
  logic [CNT_W-1:0]           hits;
  logic [CNT_W-1:0]           misses;
  logic [ROUND_W-1:0]         round_num;
  logic                       round_clear;
  logic                       game_over;
  logic [SCORE_W-1:0]         score_bin;
  logic [4*SCORE_DIGITS-1:0]  score_bcd;
  logic                       bcd_valid;

  modport master (
    output hit_evt, escape_evt,
    input  busy, birds_left, hit_mask, hits, misses, round_num,
           round_clear, game_over, score_bin, score_bcd, bcd_valid
  );

  modport slave (
    input  hit_evt, escape_evt,
    output busy, birds_left, hit_mask, hits, misses, round_num,
           round_clear, game_over, score_bin, score_bcd, bcd_valid
  );
endinterface

// File: rtl/round_scoreboard_bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one bit per cycle.
// done is high during the last shift; bcd then carries the final result.
module bin2bcd_seq #(
  parameter int SCORE_W      = 14,
  parameter int SCORE_DIGITS = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [SCORE_W-1:0]        bin,
  output logic                      done,
  output logic [4*SCORE_DIGITS-1:0] bcd
);
  localparam int BCD_W = 4 * SCORE_DIGITS;
  localparam int CNT_W = $clog2(SCORE_W + 1);

  logic [SCORE_W-1:0] sr;
  logic [BCD_W-1:0]   acc;
  logic [BCD_W-1:0]   adj;
  logic [CNT_W-1:0]   cnt;

  always_comb begin
    adj = acc;
    for (int d = 0; d < SCORE_DIGITS; d++) begin
      if (acc[4*d +: 4] >= 4'd5) adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
    end
    bcd  = (adj << 1) | BCD_W'(sr[SCORE_W-1]);
    done = (cnt == CNT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr  <= '0;
      acc <= '0;
      cnt <= '0;
    end else if (start) begin
      sr  <= bin;
      acc <= '0;
      cnt <= CNT_W'(SCORE_W);
    end else if (cnt != '0) begin
      acc <= bcd;
      sr  <= sr << 1;
      cnt <= cnt - CNT_W'(1);
    end
  end
endmodule

// File: rtl/round_scoreboard.sv
// Round, score and game-over controller for duck-hunt; score also presented as BCD.
// Optional PERFECT_BONUS_EN: a perfect round adds 10*HIT_POINTS in CHECK.
//   state   | meaning
//   IDLE    | waiting for a hit/escape event
//   CHECK   | evaluate round completion, bonus, clear or game over
//   CONVERT | double-dabble running, SCORE_W cycles
//   OVER    | game ended, events ignored until reset
module round_scoreboard import scoreboard_pkg::*; #(
  parameter int BIRDS_PER_ROUND = 10,
  parameter int PASS_HITS       = 6,
  parameter int HIT_POINTS      = 50,
  parameter int MISS_PENALTY    = 10,
  parameter int SCORE_DIGITS    = 4,
  parameter int ROUND_W         = 4
) (
  input logic               clk,
  input logic               reset,
  round_scoreboard_if.slave bus
);
  localparam int CNT_W     = $clog2(BIRDS_PER_ROUND + 1);
  localparam int SCORE_MAX = score_max_f(SCORE_DIGITS);
  localparam int SCORE_W   = score_w_f(SCORE_DIGITS);
  localparam int BCD_W     = 4 * SCORE_DIGITS;

  state_t                     state;
  logic                       go_over;
  logic [CNT_W:0]             resolved;
  logic                       full;
  logic                       passed;
  logic [BIRDS_PER_ROUND-1:0] bird_bit;
  logic [SCORE_W-1:0]         hit_score;
  logic [SCORE_W-1:0]         esc_score;
  logic [SCORE_W-1:0]         check_score;
  logic                       conv_start;
  logic                       conv_done;
  logic [BCD_W-1:0]           conv_bcd;

  always_comb begin
    resolved  = {1'b0, bus.hits} + {1'b0, bus.misses};
    full      = (resolved == (CNT_W+1)'(BIRDS_PER_ROUND));
    passed    = full && (bus.hits >= CNT_W'(PASS_HITS));
    bird_bit  = BIRDS_PER_ROUND'(1) << resolved[CNT_W-1:0];
    hit_score = SCORE_W'(sat_add(int'(bus.score_bin), HIT_POINTS, SCORE_MAX));
    esc_score = SCORE_W'(sat_sub(int'(bus.score_bin), MISS_PENALTY));
`ifdef PERFECT_BONUS_EN
    if (full && bus.hits == CNT_W'(BIRDS_PER_ROUND))
      check_score = SCORE_W'(sat_add(int'(bus.score_bin), 10 * HIT_POINTS, SCORE_MAX));
    else
      check_score = bus.score_bin;
`else
    check_score = bus.score_bin;
`endif
    conv_start = (state == CHECK);
  end

  // Converter loads the post-CHECK score on the CHECK edge so CONVERT lasts exactly SCORE_W cycles.
  bin2bcd_seq #(.SCORE_W(SCORE_W), .SCORE_DIGITS(SCORE_DIGITS)) u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .bin   (check_score),
    .done  (conv_done),
    .bcd   (conv_bcd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      go_over         <= 1'b0;
      bus.busy        <= 1'b0;
      bus.birds_left  <= '1;
      bus.hit_mask    <= '0;
      bus.hits        <= '0;
      bus.misses      <= '0;
      bus.round_num   <= '0;
      bus.round_clear <= 1'b0;
      bus.game_over   <= 1'b0;
      bus.score_bin   <= '0;
      bus.score_bcd   <= '0;
      bus.bcd_valid   <= 1'b1;
    end else begin
      bus.round_clear <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.hit_evt | bus.escape_evt) begin
            bus.birds_left <= bus.birds_left & ~bird_bit;
            if (bus.hit_evt) begin
              bus.hit_mask  <= bus.hit_mask | bird_bit;
              bus.hits      <= bus.hits + CNT_W'(1);
              bus.score_bin <= hit_score;
            end else begin
              bus.misses    <= bus.misses + CNT_W'(1);
              bus.score_bin <= esc_score;
            end
            bus.bcd_valid <= 1'b0;
            bus.busy      <= 1'b1;
            state         <= CHECK;
          end
        end
        CHECK: begin
          bus.score_bin <= check_score;
          if (passed) begin
            bus.round_clear <= 1'b1;
            if (bus.round_num != '1) bus.round_num <= bus.round_num + ROUND_W'(1);
            bus.birds_left <= '1;
            bus.hit_mask   <= '0;
            bus.hits       <= '0;
            bus.misses     <= '0;
          end else if (full) begin
            go_over <= 1'b1;
          end
          state <= CONVERT;
        end
        CONVERT: begin
          if (conv_done) begin
            bus.score_bcd <= conv_bcd;
            bus.bcd_valid <= 1'b1;
            if (go_over) begin
              bus.game_over <= 1'b1;
              state         <= OVER;
            end else begin
              bus.busy <= 1'b0;
              state    <= IDLE;
            end
          end
        end
        OVER: begin
          bus.game_over <= 1'b1;
          bus.busy      <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_round_scoreboard.sv
// Scoreboard bench for round_scoreboard: stimulus pushes expected results,
// a monitor pops and compares on each rising bcd_valid.
module tb_round_scoreboard;
  typedef struct {
    int score_bin;
    int score_bcd;
    int birds;
    int hmask;
    int hits;
    int misses;
    int round_num;
    int rc;
    int over;
  } exp_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  exp_t q[$];

  int       m_score, m_hits, m_misses, m_round;
  bit       m_over;
  bit [9:0] m_birds, m_hmask;

  round_scoreboard_if bus();

  round_scoreboard dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic int to_bcd(input int v);
    int r;
    r = 0;
    for (int d = 0; d < 4; d++) begin
      r = r | ((v % 10) << (4 * d));
      v = v / 10;
    end
    return r;
  endfunction

  function automatic void model_reset();
    m_score = 0; m_hits = 0; m_misses = 0; m_round = 0;
    m_over = 0; m_birds = '1; m_hmask = '0;
  endfunction

  function automatic exp_t snapshot(input int rc);
    exp_t x;
    x.score_bin = m_score;
    x.score_bcd = to_bcd(m_score);
    x.birds     = int'(m_birds);
    x.hmask     = int'(m_hmask);
    x.hits      = m_hits;
    x.misses    = m_misses;
    x.round_num = m_round;
    x.rc        = rc;
    x.over      = int'(m_over);
    return x;
  endfunction

  function automatic exp_t model_step(input bit h);
    int i;
    int rc;
    i  = m_hits + m_misses;
    rc = 0;
    m_birds[i] = 1'b0;
    if (h) begin
      m_hmask[i] = 1'b1;
      m_hits++;
      m_score = (m_score + 50 > 9999) ? 9999 : m_score + 50;
    end else begin
      m_misses++;
      m_score = (m_score >= 10) ? m_score - 10 : 0;
    end
    if (m_hits + m_misses == 10) begin
      if (m_hits >= 6) begin
`ifdef PERFECT_BONUS_EN
        if (m_hits == 10) m_score = (m_score + 500 > 9999) ? 9999 : m_score + 500;
`endif
        rc = 1;
        if (m_round < 15) m_round++;
        m_birds = '1; m_hmask = '0; m_hits = 0; m_misses = 0;
      end else begin
        m_over = 1;
      end
    end
    return snapshot(rc);
  endfunction

  task automatic pulse(input bit h, input bit e);
    @(negedge clk);
    bus.hit_evt = h; bus.escape_evt = e;
    @(negedge clk);
    bus.hit_evt = 1'b0; bus.escape_evt = 1'b0;
  endtask

  task automatic send(input bit h, input bit e);
    int n;
    if (m_over) begin
      pulse(h, e);
      repeat (20) @(negedge clk);
      return;
    end
    q.push_back(model_step(h));
    pulse(h, e);
    n = 0;
    while (bus.bcd_valid !== 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("latency_cycles", n, 15);
    check("busy_after", bus.busy, m_over);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin : monitor
    bit   prev;
    int   rc;
    exp_t x;
    prev = 1'b1;
    rc   = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bus.round_clear === 1'b1) rc++;
      if (prev === 1'b0 && bus.bcd_valid === 1'b1) begin
        check("expected_available", q.size() != 0, 1);
        if (q.size() != 0) begin
          x = q.pop_front();
          check("score_bin", bus.score_bin, x.score_bin);
          check("score_bcd", bus.score_bcd, x.score_bcd);
          check("birds_left", bus.birds_left, x.birds);
          check("hit_mask", bus.hit_mask, x.hmask);
          check("hits", bus.hits, x.hits);
          check("misses", bus.misses, x.misses);
          check("round_num", bus.round_num, x.round_num);
          check("game_over", bus.game_over, x.over);
          check("round_clear_pulses", rc, x.rc);
        end
        rc = 0;
      end
      prev = bus.bcd_valid;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "timeout");
  end

  initial begin : stim
    total = 0; bad = 0;
    reset = 1'b1;
    bus.hit_evt = 1'b0; bus.escape_evt = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // 1. reset values
    check("rst_score_bin", bus.score_bin, 0);
    check("rst_score_bcd", bus.score_bcd, 16'h0000);
    check("rst_bcd_valid", bus.bcd_valid, 1);
    check("rst_birds_left", bus.birds_left, 10'h3FF);
    check("rst_round_num", bus.round_num, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_game_over", bus.game_over, 0);

    // 2. single hit
    send(1, 0);
    check("hit_score", bus.score_bin, 50);
    check("hit_bcd", bus.score_bcd, 16'h0050);
    check("hit_birds", bus.birds_left, 10'h3FE);
    check("hit_mask1", bus.hit_mask, 10'h001);

    // 3. escape at score 0
    do_reset();
    send(0, 1);
    check("esc_score", bus.score_bin, 0);
    check("esc_misses", bus.misses, 1);
    check("esc_birds", bus.birds_left, 10'h3FE);
    check("esc_mask", bus.hit_mask, 10'h000);

    // 4. passing round
    do_reset();
    for (int i = 0; i < 6; i++) send(1, 0);
    for (int i = 0; i < 4; i++) send(0, 1);
    check("pass_round", bus.round_num, 1);
    check("pass_score", bus.score_bin, 260);
    check("pass_bcd", bus.score_bcd, 16'h0260);
    check("pass_birds", bus.birds_left, 10'h3FF);
    check("pass_hits", bus.hits, 0);

    // 5. failing round, then ignored event and reset
    do_reset();
    for (int i = 0; i < 5; i++) send(1, 0);
    for (int i = 0; i < 5; i++) send(0, 1);
    check("over_flag", bus.game_over, 1);
    check("over_score", bus.score_bin, 200);
    send(1, 0);
    check("over_ignore_score", bus.score_bin, 200);
    check("over_ignore_hits", bus.hits, 5);
    check("over_still_busy", bus.busy, 1);
    do_reset();
    check("over_cleared", bus.game_over, 0);

    // 6a. simultaneous hit and escape
    send(1, 1);
    check("both_hits", bus.hits, 1);
    check("both_misses", bus.misses, 0);
    check("both_score", bus.score_bin, 50);

    // 6b. pulse while busy is dropped
    do_reset();
    q.push_back(model_step(1'b1));
    pulse(1, 0);
    @(negedge clk);
    pulse(0, 1);
    begin
      int n;
      n = 0;
      while (bus.bcd_valid !== 1'b1 && n < 100) begin
        n++;
        @(negedge clk);
      end
      check("busy_drop_wait", n < 100, 1);
    end
    @(negedge clk);
    check("busy_drop_misses", bus.misses, 0);
    check("busy_drop_hits", bus.hits, 1);

    // 6c. saturation over 20 perfect rounds
    do_reset();
    for (int i = 0; i < 200; i++) send(1, 0);
    check("sat_score", bus.score_bin, 9999);
    check("sat_bcd", bus.score_bcd, 16'h9999);
    check("sat_round", bus.round_num, 15);

    // 6d. reset mid-CONVERT
    do_reset();
    pulse(1, 0);
    repeat (5) @(negedge clk);
    check("mid_busy", bus.busy, 1);
    model_reset();
    q.push_back(snapshot(0));
    reset = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_valid", bus.bcd_valid, 1);
    check("mid_rst_score", bus.score_bin, 0);
    check("mid_rst_birds", bus.birds_left, 10'h3FF);
    check("mid_rst_mask", bus.hit_mask, 0);
    check("mid_rst_hits", bus.hits, 0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_rst_stays_idle", bus.busy, 0);

    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
